// File: rtl/round_judge.sv
// Player-side round judge: debounced button vs. controller target light, emits win/lose pulses, score, reaction time.
// Win/lose pulse follows the debounced press edge by one cycle (btn->pulse = DB_CYCLES+3 edges); no backpressure, pulses are fire-and-forget.
module round_judge #(
    parameter int DB_CYCLES = 8,
    parameter int WIN_PULSE = 2,
    parameter int RESP_WIN  = 256,
    parameter int SCORE_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn,
    input  logic               leds_on,
    input  logic [1:0]         leds_ctrl,
    input  logic               clr,
    output logic               winrnd,
    output logic               losernd,
    output logic [SCORE_W-1:0] score,
    output logic [8:0]         react_time
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int PW  = $clog2(WIN_PULSE + 1);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  PULSE_LAST = PW'(WIN_PULSE - 1);
    localparam logic [8:0]     RT_LAST    = 9'(RESP_WIN - 1);

    typedef enum logic [2:0] {
        WATCH,
        RESPOND,
        WIN,
        LOSE,
        LOCKOUT
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                r_db;
    logic                r_db_d;
    logic [DBW-1:0]      r_db_cnt;
    logic [8:0]          r_rtimer;
    logic [PW-1:0]       r_pulse_cnt;
    logic [SCORE_W-1:0]  r_score;
    logic [8:0]          r_react;
    logic                r_winrnd;
    logic                r_losernd;

    logic                w_clear;
    logic                w_press;
    logic                w_target;
    logic                w_win_entry;
    logic                w_react_cap;
    logic [8:0]          w_react_val;

    assign w_clear  = rst | clr;
    assign w_press  = r_db & ~r_db_d;
    assign w_target = leds_on & (leds_ctrl == 2'b11);

    // Debounced level flips only after DB_CYCLES consecutive synced samples disagreeing with it.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db     <= 1'b0;
            r_db_d   <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            if (r_sync2 != r_db) begin
                if (r_db_cnt == DB_LAST) begin
                    r_db     <= r_sync2;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= WATCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_win_entry = 1'b0;
        w_react_cap = 1'b0;
        w_react_val = '0;
        case (r_state)
            WATCH: begin
                if (w_target) begin
                    if (w_press) begin
                        w_state_nxt = WIN;
                        w_win_entry = 1'b1;
                        w_react_cap = 1'b1;
                    end else begin
                        w_state_nxt = RESPOND;
                    end
                end else if (w_press) begin
                    w_state_nxt = LOSE;
                end
            end
            RESPOND: begin
                // Reported time counts the press cycle itself, hence rtimer + 1.
                if (w_press) begin
                    w_state_nxt = WIN;
                    w_win_entry = 1'b1;
                    w_react_cap = 1'b1;
                    w_react_val = r_rtimer + 9'd1;
                end else if (r_rtimer == RT_LAST) begin
                    w_state_nxt = LOSE;
                end
            end
            WIN, LOSE: begin
                if (r_pulse_cnt == PULSE_LAST) begin
                    w_state_nxt = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (!r_db && !w_target) begin
                    w_state_nxt = WATCH;
                end
            end
            default: w_state_nxt = WATCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_rtimer    <= '0;
            r_pulse_cnt <= '0;
            r_score     <= '0;
            r_react     <= '0;
            r_winrnd    <= 1'b0;
            r_losernd   <= 1'b0;
        end else begin
            if (r_state == WATCH && w_target) begin
                r_rtimer <= '0;
            end else if (r_state == RESPOND) begin
                r_rtimer <= r_rtimer + 9'd1;
            end

            if (w_state_nxt != r_state) begin
                r_pulse_cnt <= '0;
            end else if (r_state == WIN || r_state == LOSE) begin
                r_pulse_cnt <= r_pulse_cnt + 1'b1;
            end

            if (w_win_entry && r_score != '1) begin
                r_score <= r_score + 1'b1;
            end
            if (w_react_cap) begin
                r_react <= w_react_val;
            end

            r_winrnd  <= (w_state_nxt == WIN);
            r_losernd <= (w_state_nxt == LOSE);
        end
    end

    assign winrnd     = r_winrnd;
    assign losernd    = r_losernd;
    assign score      = r_score;
    assign react_time = r_react;

endmodule
